// File: rtl/uc_sched.sv
// uc_sched: unit-clause broadcast scheduler. Loads initial unit clauses from
// memory, round-robin arbitrates engine pushes into a broadcast FIFO, drops
// duplicate/zero literals, flags complementary literals as a conflict and
// detects propagation quiescence.
// Ports: clk, rst (async active-low); start/clear control; mem_valid/mem_lit/
// mem_done/mem_ready load path; eng_req/eng_lit/eng_gnt/eng_idle engine side;
// bc_valid/bc_lit/bc_ready broadcast; busy/done/conflict status;
// stat_bcast/stat_drop counters (live only with UC_SCHED_STATS_EN defined).

`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef UC_LENGTH
`define UC_LENGTH 256
`endif

module uc_sched #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int LIT_W      = $clog2(`UC_LENGTH),
    parameter int FIFO_DEPTH = 8,
    parameter int QUIESCE    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clear,
    input  logic                        mem_valid,
    input  logic [LIT_W-1:0]            mem_lit,
    input  logic                        mem_done,
    output logic                        mem_ready,
    input  logic [NUM_ENGINE-1:0]       eng_req,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
    output logic [NUM_ENGINE-1:0]       eng_gnt,
    input  logic [NUM_ENGINE-1:0]       eng_idle,
    output logic                        bc_valid,
    output logic [LIT_W-1:0]            bc_lit,
    input  logic                        bc_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        conflict,
    output logic [15:0]                 stat_bcast,
    output logic [15:0]                 stat_drop
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = $clog2(NUM_ENGINE);
    localparam int QW = $clog2(QUIESCE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_CONFLICT
    } state_t;

    state_t state_q, state_d;

    logic [LIT_W-1:0]      fifo_q [FIFO_DEPTH];
    logic [LIT_W-1:0]      fifo_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EW-1:0]         rr_q, rr_d;
    logic [QW-1:0]         qcnt_q, qcnt_d;

    logic             full, empty;
    logic             in_load, in_run;
    logic             gnt_any, gnt_ok;
    logic [EW-1:0]    gnt_idx;
    logic [LIT_W-1:0] cand, neg_lit;
    logic             acc, is_zero, dup_hit, neg_hit;
    logic             conf, push, pop, drop, flush;

    function automatic logic [EW-1:0] rr_idx(input logic [EW-1:0] base,
                                             input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_ENGINE) s = s - NUM_ENGINE;
        return EW'(s);
    endfunction

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign in_load = (state_q == S_LOAD);
    assign in_run  = (state_q == S_RUN);

    // Round-robin search starting at the pointer and wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            if (!gnt_any && eng_req[rr_idx(rr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(rr_q, k);
            end
        end
    end

    assign gnt_ok = in_run && !full && gnt_any;

    always_comb begin
        eng_gnt = '0;
        if (gnt_ok) eng_gnt[gnt_idx] = 1'b1;
    end

    assign mem_ready = in_load && !full;
    assign bc_valid  = (in_load || in_run) && !empty;
    assign bc_lit    = bc_valid ? fifo_q[rd_q] : '0;
    assign busy      = in_load || in_run;
    assign done      = (state_q == S_DONE);
    assign conflict  = (state_q == S_CONFLICT);
    assign pop       = bc_valid && bc_ready;

    // Literal check against every live entry, head included.
    always_comb begin
        cand    = in_load ? mem_lit : eng_lit[gnt_idx*LIT_W +: LIT_W];
        acc     = (in_load && mem_valid && mem_ready) || gnt_ok;
        neg_lit = -cand;
        is_zero = (cand == '0);
        dup_hit = 1'b0;
        neg_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i] && fifo_q[i] == cand) dup_hit = 1'b1;
            // Most-negative literal negates to itself; that is a duplicate.
            if (vld_q[i] && fifo_q[i] == neg_lit && neg_lit != cand)
                neg_hit = 1'b1;
        end
        conf = acc && !is_zero && neg_hit;
        push = acc && !is_zero && !neg_hit && !dup_hit;
        drop = acc && !neg_hit && (is_zero || dup_hit);
    end

    always_comb begin
        qcnt_d = '0;
        if (in_run && empty && eng_req == '0 && &eng_idle)
            qcnt_d = qcnt_q + QW'(1);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (conf) state_d = S_CONFLICT;
                else if (mem_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (conf) state_d = S_CONFLICT;
                else if (qcnt_d == QW'(QUIESCE)) state_d = S_DONE;
            end
            S_DONE:     if (clear) state_d = S_IDLE;
            S_CONFLICT: if (clear) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (gnt_ok) rr_d = rr_idx(gnt_idx, 1);
    end

    assign flush = (state_d == S_CONFLICT);

    always_comb begin
        fifo_d = fifo_q;
        vld_d  = vld_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (flush) begin
            vld_d = '0;
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                fifo_d[wr_q] = cand;
                vld_d[wr_q]  = 1'b1;
                wr_d         = wr_q + PW'(1);
            end
            if (pop) begin
                vld_d[rd_q] = 1'b0;
                rd_d        = rd_q + PW'(1);
            end
            if (push && !pop) cnt_d = cnt_q + CW'(1);
            if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            qcnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            qcnt_q  <= qcnt_d;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

`ifdef UC_SCHED_STATS_EN
    logic [15:0] stat_bcast_q, stat_bcast_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic        stat_clr;

    assign stat_clr = (state_q == S_IDLE) && (state_d == S_LOAD);

    always_comb begin
        stat_bcast_d = stat_bcast_q;
        stat_drop_d  = stat_drop_q;
        if (stat_clr) begin
            stat_bcast_d = '0;
            stat_drop_d  = '0;
        end else begin
            if (pop && stat_bcast_q != 16'hFFFF)
                stat_bcast_d = stat_bcast_q + 16'd1;
            if (drop && stat_drop_q != 16'hFFFF)
                stat_drop_d = stat_drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bcast_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            stat_bcast_q <= stat_bcast_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign stat_bcast = stat_bcast_q;
    assign stat_drop  = stat_drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign stat_bcast  = '0;
    assign stat_drop   = '0;
`endif

endmodule

// File: tb/tb_uc_sched.sv
// tb_uc_sched: directed scoreboard bench for uc_sched.
// Broadcast and grant expectations are queued; a negedge monitor checks them.

`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef UC_LENGTH
`define UC_LENGTH 256
`endif

module tb_uc_sched;

    localparam int NE = 4;
    localparam int LW = $clog2(`UC_LENGTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              start, clear;
    logic              mem_valid, mem_done, mem_ready;
    logic [LW-1:0]     mem_lit;
    logic [NE-1:0]     eng_req, eng_gnt, eng_idle;
    logic [NE*LW-1:0]  eng_lit;
    logic              bc_valid, bc_ready;
    logic [LW-1:0]     bc_lit;
    logic              busy, done, conflict;
    logic [15:0]       stat_bcast, stat_drop;

    int n_tests = 0;
    int n_fail  = 0;

    logic [LW-1:0] exp_bc[$];
    logic [NE-1:0] exp_gnt[$];
    logic [LW-1:0] mon_lit;
    logic [NE-1:0] mon_gnt;

    uc_sched #(
        .NUM_ENGINE(NE),
        .LIT_W(LW),
        .FIFO_DEPTH(8),
        .QUIESCE(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_done(mem_done),
        .mem_ready(mem_ready), .eng_req(eng_req), .eng_lit(eng_lit),
        .eng_gnt(eng_gnt), .eng_idle(eng_idle), .bc_valid(bc_valid),
        .bc_lit(bc_lit), .bc_ready(bc_ready), .busy(busy), .done(done),
        .conflict(conflict), .stat_bcast(stat_bcast), .stat_drop(stat_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lit(input int v);
        return LW'(v);
    endfunction

    task automatic set_lit(input int i, input int v);
        eng_lit[i*LW +: LW] = lit(v);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bc_valid && bc_ready) begin
                if (exp_bc.size() == 0) begin
                    chk("bc_unexpected", {24'd0, bc_lit}, 32'hFFFF_FFFF);
                end else begin
                    mon_lit = exp_bc.pop_front();
                    chk("bc_lit", {24'd0, bc_lit}, {24'd0, mon_lit});
                end
            end
            if (eng_gnt != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", {28'd0, eng_gnt}, 32'd0);
                end else begin
                    mon_gnt = exp_gnt.pop_front();
                    chk("eng_gnt", {28'd0, eng_gnt}, {28'd0, mon_gnt});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 0; clear = 0;
        mem_valid = 0; mem_lit = '0; mem_done = 0;
        eng_req = '0; eng_lit = '0; eng_idle = '0; bc_ready = 0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_gnt", eng_gnt, 0);
        chk("rst_bc_valid", bc_valid, 0);
        chk("rst_bc_lit", bc_lit, 0);
        rst = 1'b1;
        tick();

        // Load 10,20,30 with broadcast draining, then quiesce.
        eng_idle = '1; bc_ready = 1; start = 1;
        tick();
        start = 0;
        chk("load_busy", busy, 1);
        chk("load_mem_ready", mem_ready, 1);
        exp_bc.push_back(lit(10));
        exp_bc.push_back(lit(20));
        exp_bc.push_back(lit(30));
        mem_valid = 1; mem_lit = lit(10); tick();
        mem_lit = lit(20); tick();
        mem_lit = lit(30); tick();
        mem_valid = 0; mem_done = 1; tick();
        mem_done = 0;
        chk("q_done0", done, 0);
        chk("run_mem_ready", mem_ready, 0);
        tick();
        chk("q_done1", done, 0);
        tick();
        chk("q_done2", done, 1);
        chk("done_bc_valid", bc_valid, 0);
        chk("done_busy", busy, 0);
        clear = 1; tick(); clear = 0;
        chk("clear_done", done, 0);

        // Round-robin fill until full.
        bc_ready = 0; eng_idle = '0; start = 1;
        tick();
        start = 0; mem_done = 1; eng_req = 4'hF;
        tick();
        mem_done = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NE; i++) set_lit(i, 50 + 4 * c + i);
            exp_gnt.push_back(NE'(1 << (c % 4)));
            exp_bc.push_back(lit(50 + 4 * c + (c % 4)));
            tick();
        end
        chk("full_gnt_a", eng_gnt, 0);
        tick();
        chk("full_gnt_b", eng_gnt, 0);

        // Full with simultaneous pop: no grant this cycle, grant next.
        bc_ready = 1;
        for (int i = 0; i < NE; i++) set_lit(i, 100 + i);
        chk("full_pop_nogrant", eng_gnt, 0);
        tick();
        bc_ready = 0;
        exp_gnt.push_back(4'b0001);
        exp_bc.push_back(lit(100));
        chk("after_pop_grant", eng_gnt, 4'b0001);
        tick();
        eng_req = '0;

        // Drain to 4 entries, then asynchronous reset mid-RUN.
        bc_ready = 1;
        repeat (4) tick();
        bc_ready = 0;
        eng_req = 4'b0001; set_lit(0, 110);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_bc_valid", bc_valid, 1);
        chk("pre_rst_gnt", eng_gnt, 4'b0001);
        rst = 0;
        #1;
        chk("async_bc_valid", bc_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_gnt", eng_gnt, 0);
        chk("async_bc_lit", bc_lit, 0);
        exp_bc.delete();
        eng_req = '0;
        tick();
        rst = 1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_bc_valid", bc_valid, 0);
        chk("post_rst_done", done, 0);

        // Duplicate and zero literals are granted but dropped.
        start = 1; tick(); start = 0;
        mem_valid = 1; mem_lit = lit(5); tick();
        mem_valid = 0; mem_done = 1; tick();
        mem_done = 0;
        eng_req = 4'b0100; set_lit(2, 5);
        exp_gnt.push_back(4'b0100);
        tick();
        set_lit(2, 0);
        exp_gnt.push_back(4'b0100);
        tick();
        eng_req = '0;
`ifdef UC_SCHED_STATS_EN
        chk("stat_drop", stat_drop, 2);
`else
        chk("stat_drop_tied", stat_drop, 0);
`endif
        bc_ready = 1;
        exp_bc.push_back(lit(5));
        tick();
        bc_ready = 0;
        chk("dup_occupancy", bc_valid, 0);
        eng_idle = '1;
        tick();
        tick();
        chk("dup_done", done, 1);
`ifdef UC_SCHED_STATS_EN
        chk("stat_bcast", stat_bcast, 1);
`else
        chk("stat_bcast_tied", stat_bcast, 0);
`endif
        clear = 1; tick(); clear = 0;

        // Conflict in RUN: memory -3, engine 1 pushes 3.
        start = 1; tick(); start = 0;
        eng_idle = '0;
        mem_valid = 1; mem_lit = lit(-3); tick();
        mem_valid = 0; mem_done = 1; tick();
        mem_done = 0;
        eng_req = 4'b0010; set_lit(1, 3);
        exp_gnt.push_back(4'b0010);
        tick();
        eng_req = '0;
        chk("run_conflict", conflict, 1);
        chk("conf_bc_valid", bc_valid, 0);
        chk("conf_busy", busy, 0);
        chk("conf_mem_ready", mem_ready, 0);
        chk("conf_gnt", eng_gnt, 0);
        clear = 1; tick(); clear = 0;
        chk("conf_clear", conflict, 0);
        chk("conf_clear_busy", busy, 0);

        // Conflict detected during LOAD.
        start = 1; tick(); start = 0;
        mem_valid = 1; mem_lit = lit(7); tick();
        mem_lit = lit(-7); tick();
        mem_valid = 0;
        chk("load_conflict", conflict, 1);
        chk("load_conf_bc_valid", bc_valid, 0);
        clear = 1; tick(); clear = 0;
        chk("load_conf_clear", conflict, 0);

        chk("bc_queue_empty", exp_bc.size(), 0);
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
